gon_root_collector: RTL
=======================

# gon_root_collector

Sits at the root of the global output network (GON), the receiving end of the Y/X multicast controller chain. It walks a programmed rectangle of (row, column) tags, one point at a time. For each point it broadcasts the tag pair with `ready`, captures the value returned on the OR-reduced GON bus when `enable` comes back, and buffers tagged results in a small output FIFO toward the global buffer. It owns drain sequencing, backpressure, completion signalling and protocol-error detection.

## Interface
- `ROW_LEN`, 4, width of the Y (row) tag.
- `ID_LEN`, 5, width of the X (column) tag.
- `VALUE_LEN`, 32, width of a data value.
- `FIFO_DEPTH`, 4, output FIFO entries; must be a power of two, at least 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a drain; ignored unless IDLE.
- `row_first`, `row_last` in ROW_LEN: inclusive row range, sampled on an accepted `start`.
- `col_first`, `col_last` in ID_LEN: inclusive column range, sampled on an accepted `start`.
- `busy` out 1: high while not IDLE.
- `done` out 1: one-cycle completion pulse.
- `protocol_err` out 1: sticky error flag, cleared on an accepted `start`.
- `tag_y` out ROW_LEN: current row tag to the Y controllers.
- `tag_x` out ID_LEN: current column tag, forwarded toward the X controllers.
- `ready_out` out 1: root ready broadcast into the GON.
- `enable_in` in 1: OR-reduced enable returned from the GON.
- `value_in` in VALUE_LEN: OR-reduced value returned from the GON.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: downstream accepts the head.
- `out_data` out ROW_LEN+ID_LEN+VALUE_LEN: `{tag_y, tag_x, value}` of the head entry.

## Operation
- States: IDLE, DRAIN, FINISH.
- IDLE → DRAIN on `start`, if `row_first<=row_last` and `col_first<=col_last`. Tags load `row_first`/`col_first`. Bounds are latched. `protocol_err` is cleared.
- IDLE → FINISH on `start` with an empty range. `protocol_err` is set and no transfer occurs.
- `ready_out = (state==DRAIN) & ~fifo_full`. This is combinational from registered state.
- Transfer = `ready_out & enable_in` in the same cycle:
  - push `{tag_y, tag_x, value_in}` into the FIFO;
  - advance the tags in raster order: column increments; at `col_last` the column wraps to `col_first` and the row increments.
- Transfer at (`row_last`, `col_last`): DRAIN → FINISH. Tags hold their last value.
- FINISH → IDLE unconditionally after one cycle. `done` is high only in FINISH.
- `enable_in` high while `ready_out` is low sets `protocol_err`. Nothing is pushed.
- FIFO:
  - push and pop (`out_valid & out_ready`) in the same cycle leave the count unchanged;
  - no push when full, because `ready_out` is gated;
  - pop while empty is impossible because `out_valid` is low.
- FIFO contents drain independently of state, including after `done`.
- `start` while busy is ignored and has no side effects.

## Timing
- Reset values:
  - state IDLE;
  - `tag_y`, `tag_x`, `busy`, `done`, `protocol_err`, `ready_out` all 0;
  - FIFO empty, `out_valid`=0, `out_data`=0.
- `start` at cycle t: `busy` and `ready_out` go high at t+1, provided the FIFO is not full.
- Capture latency: value sampled at transfer edge t appears on `out_data` with `out_valid` at t+1 if the FIFO was empty.
- Throughput: one point per cycle while `enable_in` is held and `out_ready` is held.
- Last transfer at t: `done` is high at t+1, and `busy` drops at t+2.
- `rst` asserted mid-drain returns all state to reset values immediately. In-flight FIFO data is discarded.

## Structure
- `gon_pkg` holds:
  - state enum (IDLE/DRAIN/FINISH);
  - default `ROW_LEN`, `ID_LEN`, `VALUE_LEN`;
  - a packed result-entry type `{tag_y, tag_x, value}`.
- Sub-module `gon_out_fifo`: synchronous FIFO with full/empty flags and a count, instanced once. The collector holds the sequencer and error logic.

## Test plan
- Reset: assert `rst` mid-cycle → all outputs 0 asynchronously, `out_valid`=0.
- 2×2 drain: rows 1..2, cols 2..3, `enable_in`=1, `out_ready`=1, values 0xA0..0xA3 → `out_data` tags (1,2),(1,3),(2,2),(2,3) in that order, `done` one cycle after the 4th transfer, 4 entries exactly.
- Backpressure: `FIFO_DEPTH`=4, `out_ready`=0, 6-point drain → `ready_out` drops after 4 transfers. Raising `out_ready` resumes the drain. All 6 entries arrive in order with no duplicates.
- Network stall: `enable_in` low for 5 cycles mid-drain → tags hold, no push, resume on the same tag.
- Protocol errors:
  - `enable_in`=1 while IDLE → `protocol_err`=1 and the FIFO stays empty; the next valid `start` clears it.
  - `start` with `row_first`=3, `row_last`=1 → `done` pulse, `protocol_err`=1, no transfers.
- Reset mid-operation: `rst` after 2 of 4 transfers → IDLE, FIFO empty. A fresh `start` restarts from `row_first`/`col_first`.

Source files
------------

// File: rtl/gon_pkg.sv
// Shared types and default widths for the GON root collector.
package gon_pkg;

    // Default widths of the row tag, column tag and data value.
    localparam int ROW_LEN_DEF   = 4;
    localparam int ID_LEN_DEF    = 5;
    localparam int VALUE_LEN_DEF = 32;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FINISH = 2'd2
    } gon_state_e;

    // One buffered result, packed exactly as presented on out_data.
    typedef struct packed {
        logic [ROW_LEN_DEF-1:0]   tag_y;
        logic [ID_LEN_DEF-1:0]    tag_x;
        logic [VALUE_LEN_DEF-1:0] value;
    } gon_entry_t;

endpackage

// File: rtl/gon_out_fifo.sv
// Small synchronous FIFO that buffers tagged results toward the global buffer.
// Push is dropped when full and pop is ignored when empty, so the producer and
// consumer only need to respect the flags for correctness, not for safety.
module gon_out_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]     ZERO_CNT = (AW+1)'(0);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_s, empty_s;
    logic             push_ok_s, pop_ok_s;

    assign full_s    = (count_q == FULL_CNT);
    assign empty_s   = (count_q == ZERO_CNT);
    assign push_ok_s = push & ~full_s;
    assign pop_ok_s  = pop & ~empty_s;
    assign full      = full_s;
    assign empty     = empty_s;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Head entry; forced to zero when empty so stale data never leaks out.
    always_comb begin
        if (empty_s) begin
            head_data = '0;
        end else begin
            head_data = mem_q[rd_ptr_q];
        end
    end

    // FIFO state registers; reset discards all buffered entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/gon_root_collector.sv
// Root of the global output network: walks a rectangle of (row, column) tags
// in raster order, collects one OR-reduced value per point and buffers the
// tagged results in an output FIFO. Also flags protocol violations.
module gon_root_collector
    import gon_pkg::*;
#(
    parameter int ROW_LEN    = ROW_LEN_DEF,
    parameter int ID_LEN     = ID_LEN_DEF,
    parameter int VALUE_LEN  = VALUE_LEN_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ROW_LEN-1:0]                row_first,
    input  logic [ROW_LEN-1:0]                row_last,
    input  logic [ID_LEN-1:0]                 col_first,
    input  logic [ID_LEN-1:0]                 col_last,
    output logic                              busy,
    output logic                              done,
    output logic                              protocol_err,
    output logic [ROW_LEN-1:0]                tag_y,
    output logic [ID_LEN-1:0]                 tag_x,
    output logic                              ready_out,
    input  logic                              enable_in,
    input  logic [VALUE_LEN-1:0]              value_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ROW_LEN+ID_LEN+VALUE_LEN-1:0] out_data
);

    localparam int                ENTRY_W = ROW_LEN + ID_LEN + VALUE_LEN;
    localparam logic [ROW_LEN-1:0] ROW_ONE = ROW_LEN'(1);
    localparam logic [ID_LEN-1:0]  COL_ONE = ID_LEN'(1);

    gon_state_e          state_q, state_d;
    logic [ROW_LEN-1:0]  tag_y_q, tag_y_d;
    logic [ID_LEN-1:0]   tag_x_q, tag_x_d;
    logic [ROW_LEN-1:0]  row_first_q, row_first_d;
    logic [ROW_LEN-1:0]  row_last_q, row_last_d;
    logic [ID_LEN-1:0]   col_first_q, col_first_d;
    logic [ID_LEN-1:0]   col_last_q, col_last_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                range_ok_s;
    logic                start_acc_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                ready_s;
    logic                xfer_s;
    logic                pop_s;
    logic                last_pt_s;
    logic                err_base_s;
    logic [ENTRY_W-1:0]  push_entry_s;
    logic [ENTRY_W-1:0]  head_entry_s;

    assign range_ok_s   = (row_first <= row_last) && (col_first <= col_last);
    assign start_acc_s  = start && (state_q == ST_IDLE);
    // The network is only offered a point while there is room to store it.
    assign ready_s      = (state_q == ST_DRAIN) && !fifo_full_s;
    assign xfer_s       = ready_s && enable_in;
    assign pop_s        = !fifo_empty_s && out_ready;
    assign last_pt_s    = (tag_y_q == row_last_q) && (tag_x_q == col_last_q);
    assign push_entry_s = {tag_y_q, tag_x_q, value_in};

    assign busy         = busy_q;
    assign done         = done_q;
    assign protocol_err = err_q;
    assign tag_y        = tag_y_q;
    assign tag_x        = tag_x_q;
    assign ready_out    = ready_s;
    assign out_valid    = !fifo_empty_s;
    assign out_data     = head_entry_s;

    gon_out_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (xfer_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head_data (head_entry_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Sequencer: start acceptance, raster tag walk and completion.
    always_comb begin
        state_d     = state_q;
        tag_y_d     = tag_y_q;
        tag_x_d     = tag_x_q;
        row_first_d = row_first_q;
        row_last_d  = row_last_q;
        col_first_d = col_first_q;
        col_last_d  = col_last_q;
        case (state_q)
            ST_IDLE: begin
                if (start && range_ok_s) begin
                    state_d     = ST_DRAIN;
                    tag_y_d     = row_first;
                    tag_x_d     = col_first;
                    row_first_d = row_first;
                    row_last_d  = row_last;
                    col_first_d = col_first;
                    col_last_d  = col_last;
                end else if (start) begin
                    // Empty rectangle: report completion without any transfer.
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (xfer_s && last_pt_s) begin
                    // Tags stay on the final point.
                    state_d = ST_FINISH;
                end else if (xfer_s && (tag_x_q == col_last_q)) begin
                    tag_x_d = col_first_q;
                    tag_y_d = tag_y_q + ROW_ONE;
                end else if (xfer_s) begin
                    tag_x_d = tag_x_q + COL_ONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky protocol error: cleared by a good start, set by a bad start or
    // by an enable that arrives while the root is not offering a point.
    always_comb begin
        if (start_acc_s) begin
            err_base_s = !range_ok_s;
        end else begin
            err_base_s = err_q;
        end
        if (enable_in && !ready_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_base_s;
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FINISH);
    end

    // Collector state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tag_y_q     <= '0;
            tag_x_q     <= '0;
            row_first_q <= '0;
            row_last_q  <= '0;
            col_first_q <= '0;
            col_last_q  <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_y_q     <= tag_y_d;
            tag_x_q     <= tag_x_d;
            row_first_q <= row_first_d;
            row_last_q  <= row_last_d;
            col_first_q <= col_first_d;
            col_last_q  <= col_last_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule
